// File: rtl/ram_bist_mux_if.sv
// 32-bit single-port RAM interface (byte write enables, 1-cycle read latency).
// The master drives the request and samples Do; the slave answers it.
interface ram_bist_mux_if #(
  parameter int AW = 13
);
  logic [3:0]    WE;
  logic          EN;
  logic [31:0]   Di;
  logic [AW-1:0] A;
  logic [31:0]   Do;

  modport master (output WE, EN, Di, A, input Do);
  modport slave  (input WE, EN, Di, A, output Do);
endinterface

// File: rtl/ram_bist_mux.sv
// RAM port mux with a built-in March C- self-test over DEPTH words.
// Build option BIST_CHECKERBOARD_EN selects 5555/AAAA backgrounds instead of 0000/FFFF.
//
// state | meaning
// IDLE  | bridge port passes through to the RAM
// M0    | up,   w D0
// M1    | up,   r D0 then w D1 (r_phase selects read/write)
// M2    | up,   r D1 then w D0
// M3    | down, r D0 then w D1
// M4    | down, r D1 then w D0
// M5    | up,   r D0
// CHK   | compares the final M5 read
// DONE  | one-cycle done pulse, port already handed back
module ram_bist_mux #(
  parameter int DEPTH = 6144,
  parameter int AW    = 13
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          bist_start_i,
  output logic          bist_busy_o,
  output logic          bist_done_o,
  output logic          bist_pass_o,
  output logic [AW-1:0] bist_fail_addr_o,
  output logic [31:0]   bist_fail_data_o,
  ram_bist_mux_if.slave  s,
  ram_bist_mux_if.master m
);

`ifdef BIST_CHECKERBOARD_EN
  localparam logic [31:0] D0 = 32'h5555_5555;
  localparam logic [31:0] D1 = 32'hAAAA_AAAA;
`else
  localparam logic [31:0] D0 = 32'h0000_0000;
  localparam logic [31:0] D1 = 32'hFFFF_FFFF;
`endif
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_CHK, S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_phase, w_phase_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic          r_cmp_vld;
  logic [AW-1:0] r_cmp_addr;
  logic [31:0]   r_cmp_exp;
  logic          r_pass;
  logic [AW-1:0] r_fail_addr;
  logic [31:0]   r_fail_data;

  logic          w_en, w_rd, w_step, w_up, w_last, w_busy, w_mismatch;
  logic [3:0]    w_we;
  logic [31:0]   w_di, w_exp;

  assign w_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_mismatch = r_cmp_vld && (m.Do != r_cmp_exp);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = 1'b0;
    w_addr_nxt  = r_addr;
    w_en        = 1'b0;
    w_we        = 4'h0;
    w_di        = D0;
    w_rd        = 1'b0;
    w_exp       = D0;
    w_step      = 1'b0;
    w_up        = 1'b1;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bist_start_i) begin
          w_state_nxt = S_M0;
          w_addr_nxt  = '0;
        end
      end
      S_M0: begin
        w_en   = 1'b1;
        w_we   = 4'hF;
        w_step = 1'b1;
      end
      S_M1, S_M2, S_M3, S_M4: begin
        w_en        = 1'b1;
        w_up        = (r_state == S_M1) || (r_state == S_M2);
        w_exp       = (r_state == S_M1 || r_state == S_M3) ? D0 : D1;
        w_di        = (r_state == S_M1 || r_state == S_M3) ? D1 : D0;
        w_phase_nxt = ~r_phase;
        w_step      = r_phase;
        if (r_phase) w_we = 4'hF;
        else         w_rd = 1'b1;
      end
      S_M5: begin
        w_en   = 1'b1;
        w_rd   = 1'b1;
        w_step = 1'b1;
      end
      S_CHK:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_last = w_up ? (r_addr == LAST) : (r_addr == '0);
    // Element boundaries load the next element's start address directly, so no idle cycle.
    if (w_step) begin
      if (!w_last) begin
        w_addr_nxt = w_up ? r_addr + 1'b1 : r_addr - 1'b1;
      end else begin
        case (r_state)
          S_M0:    begin w_state_nxt = S_M1;  w_addr_nxt = '0;   end
          S_M1:    begin w_state_nxt = S_M2;  w_addr_nxt = '0;   end
          S_M2:    begin w_state_nxt = S_M3;  w_addr_nxt = LAST; end
          S_M3:    begin w_state_nxt = S_M4;  w_addr_nxt = LAST; end
          S_M4:    begin w_state_nxt = S_M5;  w_addr_nxt = '0;   end
          default: begin w_state_nxt = S_CHK; w_addr_nxt = '0;   end
        endcase
      end
    end

    if (w_mismatch) begin
      w_state_nxt = S_DONE;
      w_phase_nxt = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= S_IDLE;
      r_phase     <= 1'b0;
      r_addr      <= '0;
      r_cmp_vld   <= 1'b0;
      r_cmp_addr  <= '0;
      r_cmp_exp   <= '0;
      r_pass      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_addr     <= w_addr_nxt;
      // A read issued in the aborting cycle must not produce a second capture.
      r_cmp_vld  <= w_rd && !w_mismatch;
      r_cmp_addr <= r_addr;
      r_cmp_exp  <= w_exp;
      if (r_state == S_IDLE && bist_start_i) begin
        r_pass      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else if (w_mismatch) begin
        r_fail_addr <= r_cmp_addr;
        r_fail_data <= m.Do;
      end else if (r_state == S_CHK) begin
        r_pass <= 1'b1;
      end
    end
  end

  assign m.EN = w_busy ? w_en : s.EN;
  assign m.WE = w_busy ? w_we : s.WE;
  assign m.Di = w_busy ? w_di : s.Di;
  assign m.A  = w_busy ? r_addr : s.A;
  assign s.Do = m.Do;

  assign bist_busy_o      = w_busy;
  assign bist_done_o      = (r_state == S_DONE);
  assign bist_pass_o      = r_pass;
  assign bist_fail_addr_o = r_fail_addr;
  assign bist_fail_data_o = r_fail_data;

endmodule

// File: tb/tb_ram_bist_mux.sv
// Scoreboard bench for ram_bist_mux: DEPTH=16 with a 1-cycle-latency RAM model
// that can inject a stuck-at-1 bit on one address.
module tb_ram_bist_mux;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef BIST_CHECKERBOARD_EN
  localparam logic [31:0] D0 = 32'h5555_5555;
  localparam logic [31:0] D1 = 32'hAAAA_AAAA;
`else
  localparam logic [31:0] D0 = 32'h0000_0000;
  localparam logic [31:0] D1 = 32'hFFFF_FFFF;
`endif

  typedef struct {
    int            cycles;
    logic          pass;
    logic          chk_fail;
    logic [AW-1:0] faddr;
    logic [31:0]   fdata;
  } run_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [AW-1:0] faddr;
  logic [31:0]   fdata;

  int vecs = 0;
  int errs = 0;

  run_t        sb_q[$];
  logic [31:0] rd_q[$];

  logic [31:0]   mem [DEPTH];
  logic          fault_en = 1'b0;
  logic [AW-1:0] fault_addr = 4'd5;
  logic [31:0]   fault_mask = 32'h0000_0008;
  int            bad_wr = 0;

  ram_bist_mux_if #(.AW(AW)) s_if ();
  ram_bist_mux_if #(.AW(AW)) m_if ();

  ram_bist_mux #(.DEPTH(DEPTH), .AW(AW)) dut (
    .wb_clk_i         (clk),
    .wb_rst_ni        (rst_n),
    .bist_start_i     (start),
    .bist_busy_o      (busy),
    .bist_done_o      (done),
    .bist_pass_o      (pass),
    .bist_fail_addr_o (faddr),
    .bist_fail_data_o (fdata),
    .s                (s_if),
    .m                (m_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_if.EN) begin
      if (m_if.WE != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (m_if.WE[b]) mem[m_if.A][8*b +: 8] <= m_if.Di[8*b +: 8];
        if (m_if.Di == 32'hDEAD_BEEF) bad_wr <= bad_wr + 1;
      end else begin
        m_if.Do <= (fault_en && m_if.A == fault_addr) ? (mem[m_if.A] | fault_mask)
                                                      : mem[m_if.A];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < max && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      vecs++;
      errs++;
      $display("FAIL done_timeout: no done pulse within %0d cycles", max);
    end
    tick();
  endtask

  // Monitor: pops expected bridge read data and expected run results.
  initial begin : monitor
    int   bcnt;
    logic pend;
    run_t e;
    bcnt = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && rd_q.size() > 0) check("s_Do", s_if.Do, rd_q.pop_front());
      pend = s_if.EN && (s_if.WE == 4'h0) && !busy && rst_n;
      if (busy) bcnt++;
      if (done) begin
        if (sb_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL done_unexpected: got done pulse, expected none");
        end else begin
          e = sb_q.pop_front();
          check("run_cycles", 32'(bcnt), 32'(e.cycles));
          check("run_pass", 32'(pass), 32'(e.pass));
          check("run_busy_at_done", 32'(busy), 32'd0);
          if (e.chk_fail) begin
            check("fail_addr", 32'(faddr), 32'(e.faddr));
            check("fail_data", fdata, e.fdata);
          end
        end
        bcnt = 0;
      end else if (!busy) begin
        bcnt = 0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    s_if.EN = 1'b0;
    s_if.WE = 4'h0;
    s_if.Di = '0;
    s_if.A  = '0;
    m_if.Do = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    #23;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_faddr", 32'(faddr), 32'd0);
    check("rst_fdata", fdata, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Idle passthrough
    s_if.EN = 1'b1; s_if.WE = 4'hF; s_if.A = 4'd3; s_if.Di = 32'h1234_5678;
    #1;
    check("pt_m_A", 32'(m_if.A), 32'd3);
    check("pt_m_Di", m_if.Di, 32'h1234_5678);
    check("pt_m_WE", 32'(m_if.WE), 32'hF);
    check("pt_m_EN", 32'(m_if.EN), 32'd1);
    tick();
    s_if.WE = 4'h0;
    rd_q.push_back(32'h1234_5678);
    #1;
    check("pt_rd_m_WE", 32'(m_if.WE), 32'd0);
    check("pt_rd_m_A", 32'(m_if.A), 32'd3);
    tick();
    s_if.EN = 1'b0;
    tick();
    tick();

    // Fault-free run
    sb_q.push_back('{cycles: 161, pass: 1'b1, chk_fail: 1'b0, faddr: '0, fdata: '0});
    pulse_start();
    check("m0_busy", 32'(busy), 32'd1);
    check("m0_first_di", m_if.Di, D0);
    check("m0_first_we", 32'(m_if.WE), 32'hF);
    check("m0_first_a", 32'(m_if.A), 32'd0);
    repeat (17) tick();
    check("m1_first_di", m_if.Di, D1);
    check("m1_first_we", 32'(m_if.WE), 32'hF);
    check("m1_first_a", 32'(m_if.A), 32'd0);
    wait_done(200);
    tick();
    check("pass_held", 32'(pass), 32'd1);

    // Stuck-at-1 on bit 3 of address 5: caught on the M1 read of address 5
    fault_en = 1'b1;
    sb_q.push_back('{cycles: 28, pass: 1'b0, chk_fail: 1'b1, faddr: 4'd5, fdata: D0 | 32'h8});
    pulse_start();
    wait_done(200);
    fault_en = 1'b0;
    tick();
    check("fault_pass_held", 32'(pass), 32'd0);
    check("fault_idle", 32'(busy), 32'd0);

    // Re-start and bridge write while busy are both ignored
    sb_q.push_back('{cycles: 161, pass: 1'b1, chk_fail: 1'b0, faddr: '0, fdata: '0});
    pulse_start();
    repeat (40) tick();
    pulse_start();
    repeat (10) tick();
    s_if.EN = 1'b1; s_if.WE = 4'hF; s_if.A = 4'd2; s_if.Di = 32'hDEAD_BEEF;
    tick();
    s_if.EN = 1'b0; s_if.WE = 4'h0;
    wait_done(200);
    check("no_bridge_wr", 32'(bad_wr), 32'd0);
    check("mem2_final", mem[2], D0);

    // Reset during M3
    pulse_start();
    repeat (90) tick();
    check("m3_busy", 32'(busy), 32'd1);
    s_if.A = 4'd7; s_if.Di = 32'hCAFE_0001; s_if.WE = 4'h3;
    #2 rst_n = 1'b0;
    #1;
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_pass", 32'(pass), 32'd0);
    check("rr_done", 32'(done), 32'd0);
    check("rr_m_A", 32'(m_if.A), 32'd7);
    check("rr_m_Di", m_if.Di, 32'hCAFE_0001);
    check("rr_m_WE", 32'(m_if.WE), 32'h3);
    check("rr_m_EN", 32'(m_if.EN), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    s_if.WE = 4'h0;
    repeat (20) tick();
    check("rr_stay_idle", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
